uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//   Shares one UART transmitter (driven by the baud-rate generator tick domain) between
//   N_REQ byte producers, e.g. keyboard echo and display status.
//   Round-robin arbitration, one byte per grant; sequences tx_start and tracks tx_busy.
//   Sits between the producers and uart_tx in the top level.
// PARAMETERS
//   N_REQ          2          number of requesters (2..4)
//   DATA_W         8          byte width
//   TIMEOUT_CYCLES 2_000_000  watchdog limit in clk cycles (used only with UART_ARB_TIMEOUT_EN)
// PORTS
//   clk          in   1             system clock; all logic on posedge
//   rst          in   1             synchronous, active-high reset
//   req          in   N_REQ         per-requester send request (level)
//   req_data     in   N_REQ*DATA_W  byte i at [i*DATA_W +: DATA_W]
//   gnt          out  N_REQ         one-hot, 1-cycle pulse: byte i accepted
//   tx_start     out  1             1-cycle pulse to uart_tx
//   tx_data      out  DATA_W        byte to uart_tx; held stable from tx_start until return to IDLE
//   tx_busy      in   1             uart_tx busy (high while shifting a frame)
//   arb_busy     out  1             state != IDLE
//   timeout_err  out  1             1-cycle pulse on watchdog abort (tied 0 without macro)
// BEHAVIOUR
//   Reset: state=IDLE, gnt=0, tx_start=0, tx_data=0, timeout_err=0, rr pointer=0 (req0 highest).
//   Reset mid-transfer abandons the byte; tx_start is not reissued.
//   FSM, all outputs registered:
//     IDLE:      if tx_busy==0 and |req: winner = first set req at or after ptr (mod N_REQ);
//                next cycle: gnt[winner]=1, tx_start=1, tx_data=req_data[winner];
//                ptr <= winner+1 mod N_REQ; go WAIT_BUSY.
//                If tx_busy==1 (external or previous frame), no grant; stay IDLE.
//     WAIT_BUSY: wait tx_busy==1 -> WAIT_IDLE.
//     WAIT_IDLE: wait tx_busy==0 -> IDLE.
//   Latency: req sampled in IDLE at cycle N -> gnt/tx_start at N+1.
//   After tx_busy falls at cycle M, state is IDLE at M+1; next grant no earlier than M+2.
//   Requesters hold req and req_data stable until gnt, then drop req or present the next byte.
//   req dropped before gnt = withdrawn; no transfer, no gnt.
//   req still high on the gnt cycle is not re-sampled; the FSM is past IDLE.
//   Simultaneous requests: rr order; with all requesters asserted continuously, grants rotate 0,1,..,N-1,0.
//   Single requester: granted back-to-back, one byte per frame; the pointer does not starve it.
//   tx_busy rising on the tx_start cycle is accepted: WAIT_BUSY exits on the next edge.
// CONFIGURATION
//   UART_ARB_TIMEOUT_EN defined:
//     - Cycle counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY/WAIT_IDLE.
//     - When it reaches TIMEOUT_CYCLES-1: go IDLE, pulse timeout_err 1 cycle.
//     - The rr pointer keeps its advanced value.
//   UART_ARB_TIMEOUT_EN undefined: no counter; timeout_err constant 0; waits are unbounded.
// STRUCTURE
//   Package uart_arb_pkg: state localparams (IDLE=0, WAIT_BUSY=1, WAIT_IDLE=2), DATA_W default,
//     clog2 helper for pointer width.
//   Sub-module rr_pick: combinational; inputs (req, ptr), outputs (valid, one-hot winner, index).
//   Top holds the FSM, registers and watchdog.
// TESTING
//   1 Reset, then req=2'b01, data0=8'h41, stub tx_busy high 3 cycles after start
//     -> gnt=01 and tx_start at N+1, tx_data=8'h41, back to IDLE after busy falls.
//   2 req=2'b11 held for 4 bytes -> gnt order 01,10,01,10.
//     tx_start count=4; each tx_data matches its granted requester.
//   3 tx_busy forced high in IDLE with req=01 -> no gnt or tx_start until tx_busy low,
//     then gnt at the following cycle.
//   4 req0 pulsed for 1 cycle while the FSM is in WAIT_IDLE -> no grant ever issued to req0.
//   5 rst asserted in WAIT_IDLE -> next cycle all outputs 0, arb_busy=0.
//     After release, req=11 grants req0 first.
//   6 (UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16) tx_busy never rises
//     -> timeout_err pulse 16 cycles after tx_start, IDLE, next grant to req1.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared constants for the UART transmit arbiter: FSM state codes, default byte width
// and a width helper for the round-robin pointer and watchdog counter.
package uart_arb_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_IDLE = 2'd2;

  localparam int DATA_W_DEFAULT = 8;

  // ceil(log2(n)) clamped to at least one bit, so a 1-entry range still gets a register
  function automatic int clog2_min1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: selects the first asserted request at or after ptr (wrapping),
// reporting a valid flag, a one-hot winner and the winner's index. Purely combinational.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int PTR_W = clog2_min1(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [N_REQ-1:0] winner,
  output logic [PTR_W-1:0] index
);

  // Scan from the farthest candidate back toward ptr so the nearest hit is assigned last.
  always_comb begin
    int               pos;
    logic [N_REQ-1:0] shifted;
    valid   = 1'b0;
    index   = '0;
    pos     = 0;
    shifted = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      shifted = req >> pos;
      if (shifted[0]) begin
        valid = 1'b1;
        index = PTR_W'(pos);
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
    assign winner[gi] = valid && (index == PTR_W'(gi));
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte producers, one byte per grant.
// Optional watchdog that aborts a stuck frame is enabled with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ          = 2,
  parameter int DATA_W         = DATA_W_DEFAULT,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_busy,
  output logic                    arb_busy,
  output logic                    timeout_err
);

  localparam int PTR_W = clog2_min1(N_REQ);

  logic [1:0]        state_reg;
  logic [PTR_W-1:0]  ptr_reg;
  logic [N_REQ-1:0]  gnt_reg;
  logic              tx_start_reg;
  logic [DATA_W-1:0] tx_data_reg;

  logic              pick_valid;
  logic [N_REQ-1:0]  pick_winner;
  logic [PTR_W-1:0]  pick_index;
  logic [PTR_W-1:0]  ptr_next;
  logic              grant_fire;
  logic [DATA_W-1:0] data_arr [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .valid  (pick_valid),
    .winner (pick_winner),
    .index  (pick_index)
  );

  // Pointer moves just past the winner so a lone requester is still served every frame.
  assign ptr_next   = (pick_index == PTR_W'(N_REQ - 1)) ? '0 : pick_index + PTR_W'(1);
  assign grant_fire = (state_reg == ST_IDLE) && !tx_busy && pick_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wd_cnt_reg;
  logic             timeout_err_reg;
  logic             wd_expire;

  assign wd_expire = (state_reg != ST_IDLE) && (wd_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg      <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      timeout_err_reg <= wd_expire;
      if (grant_fire) begin
        wd_cnt_reg <= '0;
      end else if (state_reg != ST_IDLE && !wd_expire) begin
        wd_cnt_reg <= wd_cnt_reg + CNT_W'(1);
      end
    end
  end

  assign timeout_err = timeout_err_reg;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      ptr_reg      <= '0;
      gnt_reg      <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
    end else begin
      gnt_reg      <= '0;
      tx_start_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (grant_fire) begin
            gnt_reg      <= pick_winner;
            tx_start_reg <= 1'b1;
            tx_data_reg  <= data_arr[pick_index];
            ptr_reg      <= ptr_next;
            state_reg    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: if (tx_busy) state_reg <= ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (!tx_busy) state_reg <= ST_IDLE;
        default:      state_reg <= ST_IDLE;
      endcase
`ifdef UART_ARB_TIMEOUT_EN
      // Abort overrides the normal wait transitions; the pointer keeps its advanced value.
      if (wd_expire) state_reg <= ST_IDLE;
`endif
    end
  end

  assign gnt      = gnt_reg;
  assign tx_start = tx_start_reg;
  assign tx_data  = tx_data_reg;
  assign arb_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized frames
// against a round-robin reference model. Timeout scenario runs only with UART_ARB_TIMEOUT_EN.
module tb_uart_tx_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic            tx_start;
  logic [DW-1:0]   tx_data;
  logic            tx_busy;
  logic            arb_busy;
  logic            timeout_err;

  int checks  = 0;
  int errors  = 0;
  int ref_ptr = 0;
  int starts  = 0;
  logic [N-1:0] last_gnt;

  uart_tx_arbiter #(
    .N_REQ          (N),
    .DATA_W         (DW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .arb_busy    (arb_busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: first asserted requester at or after the pointer, wrapping around.
  function automatic int model_winner(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (p + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // One full frame: grant expected on the next edge, uart stub raises busy after d1 cycles
  // and holds it for len cycles; arbiter must be idle one cycle after busy falls.
  task automatic run_frame(input int d1, input int len, input logic [N-1:0] next_req);
    int            w;
    logic [N-1:0]  exp_gnt;
    logic [DW-1:0] exp_data;
    w        = model_winner(req, ref_ptr);
    exp_gnt  = '0;
    exp_data = '0;
    if (w >= 0) begin
      exp_gnt[w] = 1'b1;
      exp_data   = req_data[w*DW +: DW];
    end
    step();
    checks++;
    if (gnt !== exp_gnt) begin
      errors++; $display("FAIL grant: gnt=%b expected %b", gnt, exp_gnt);
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++; $display("FAIL tx_start: got %b expected 1", tx_start);
    end
    checks++;
    if (tx_data !== exp_data) begin
      errors++; $display("FAIL tx_data: got %h expected %h", tx_data, exp_data);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got %b expected 0", timeout_err);
    end
    $display("frame: gnt=%b tx_data=%h d1=%0d len=%0d", gnt, tx_data, d1, len);
    last_gnt = gnt;
    if (tx_start === 1'b1) starts++;
    if (w >= 0) begin
      ref_ptr = (w + 1) % N;
      req_data[w*DW +: DW] = DW'($urandom);
    end
    req = next_req;
    if (d1 == 0) tx_busy = 1'b1;
    for (int i = 0; i < d1; i++) begin
      step();
      checks++;
      if (gnt !== '0 || tx_start !== 1'b0 || arb_busy !== 1'b1) begin
        errors++;
        $display("FAIL wait_busy: gnt=%b tx_start=%b arb_busy=%b expected 00/0/1", gnt, tx_start, arb_busy);
      end
    end
    tx_busy = 1'b1;
    for (int i = 0; i < len; i++) begin
      step();
      checks++;
      if (gnt !== '0 || tx_start !== 1'b0 || arb_busy !== 1'b1 || tx_data !== exp_data) begin
        errors++;
        $display("FAIL wait_idle: gnt=%b tx_start=%b arb_busy=%b tx_data=%h expected 00/0/1/%h",
                 gnt, tx_start, arb_busy, tx_data, exp_data);
      end
    end
    tx_busy = 1'b0;
    step();
    checks++;
    if (arb_busy !== 1'b0 || gnt !== '0) begin
      errors++; $display("FAIL return_idle: arb_busy=%b gnt=%b expected 0/00", arb_busy, gnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0; tx_busy = 1'b0;
    repeat (3) step();
    checks++;
    if (gnt !== '0) begin errors++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++;
    if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
    checks++;
    if (tx_data !== '0) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    checks++;
    if (arb_busy !== 1'b0) begin errors++; $display("FAIL reset_arb_busy: got %b expected 0", arb_busy); end
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
    rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_single();
    req = 2'b01;
    req_data[7:0] = 8'h41;
    run_frame(0, 3, 2'b01);
    run_frame(1, 2, 2'b01);
    run_frame(2, 1, 2'b00);
    checks++;
    if (last_gnt !== 2'b01) begin errors++; $display("FAIL single_starve: gnt=%b expected 01", last_gnt); end
  endtask

  task automatic test_round_robin();
    int base;
    logic [N-1:0] exp;
    req = '0; rst = 1'b1; step(); rst = 1'b0; ref_ptr = 0;
    req_data = {DW'($urandom), DW'($urandom)};
    req  = 2'b11;
    base = starts;
    for (int i = 0; i < 4; i++) begin
      run_frame(i % 3, 2, (i == 3) ? 2'b00 : 2'b11);
      exp = (i % 2 == 0) ? 2'b01 : 2'b10;
      checks++;
      if (last_gnt !== exp) begin errors++; $display("FAIL rr_order[%0d]: gnt=%b expected %b", i, last_gnt, exp); end
    end
    checks++;
    if (starts - base !== 4) begin errors++; $display("FAIL rr_starts: got %0d expected 4", starts - base); end
  endtask

  task automatic test_busy_hold();
    req = 2'b01;
    req_data[7:0] = DW'($urandom);
    tx_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (gnt !== '0 || tx_start !== 1'b0) begin
        errors++; $display("FAIL busy_hold: gnt=%b tx_start=%b expected 00/0", gnt, tx_start);
      end
    end
    tx_busy = 1'b0;
    run_frame(1, 2, 2'b00);
  endtask

  task automatic test_withdraw();
    req = 2'b10;
    req_data[15:8] = DW'($urandom);
    step();
    checks++;
    if (gnt !== 2'b10) begin errors++; $display("FAIL withdraw_setup: gnt=%b expected 10", gnt); end
    ref_ptr = 0;
    req = 2'b00; tx_busy = 1'b1;
    step();
    req = 2'b01;
    step();
    req = 2'b00;
    step();
    tx_busy = 1'b0;
    step();
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (gnt !== '0 || tx_start !== 1'b0 || arb_busy !== 1'b0) begin
        errors++;
        $display("FAIL withdraw: gnt=%b tx_start=%b arb_busy=%b expected 00/0/0", gnt, tx_start, arb_busy);
      end
    end
  endtask

  task automatic test_reset_mid();
    req = 2'b11;
    req_data = {DW'($urandom), DW'($urandom)};
    step();
    checks++;
    if (tx_start !== 1'b1) begin errors++; $display("FAIL rstmid_setup: tx_start=%b expected 1", tx_start); end
    req = 2'b00; tx_busy = 1'b1;
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if (gnt !== '0 || tx_start !== 1'b0 || tx_data !== '0 || timeout_err !== 1'b0 || arb_busy !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: gnt=%b tx_start=%b tx_data=%h terr=%b arb_busy=%b expected all 0",
               gnt, tx_start, tx_data, timeout_err, arb_busy);
    end
    rst = 1'b0; tx_busy = 1'b0; ref_ptr = 0;
    req = 2'b11;
    run_frame(0, 2, 2'b00);
    checks++;
    if (last_gnt !== 2'b01) begin errors++; $display("FAIL rstmid_first: gnt=%b expected 01", last_gnt); end
  endtask

  task automatic test_random();
    req = N'($urandom_range(1, (1 << N) - 1));
    req_data = {DW'($urandom), DW'($urandom)};
    for (int i = 0; i < 24; i++) begin
      run_frame($urandom_range(0, 3), $urandom_range(1, 5),
                (i == 23) ? '0 : N'($urandom_range(1, (1 << N) - 1)));
    end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = '0; rst = 1'b1; step(); rst = 1'b0; ref_ptr = 0;
    req = 2'b11;
    step();
    checks++;
    if (gnt !== 2'b01 || tx_start !== 1'b1) begin
      errors++; $display("FAIL to_grant: gnt=%b tx_start=%b expected 01/1", gnt, tx_start);
    end
    ref_ptr = 1;
    for (int i = 0; i < 15; i++) begin
      step();
      checks++;
      if (timeout_err !== 1'b0 || arb_busy !== 1'b1) begin
        errors++; $display("FAIL to_early: cycle %0d terr=%b arb_busy=%b expected 0/1", i + 1, timeout_err, arb_busy);
      end
    end
    step();
    checks++;
    if (timeout_err !== 1'b1 || arb_busy !== 1'b0) begin
      errors++; $display("FAIL to_pulse: terr=%b arb_busy=%b expected 1/0", timeout_err, arb_busy);
    end
    run_frame(0, 2, 2'b00);
    checks++;
    if (last_gnt !== 2'b10) begin errors++; $display("FAIL to_next: gnt=%b expected 10", last_gnt); end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_busy_hold();
    test_withdraw();
    test_reset_mid();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
